// File: rtl/keypad_decoder.sv
// keypad_decoder
//   Scans a 4x4 active-low matrix keypad one column at a time, synchronises
//   the row returns, picks the lowest pressed key index per full scan frame,
//   debounces the per-frame result and presents it as a level code.
//
// Parameters
//   SCAN_DIV  clock cycles each column stays driven (>= 4)
//   DEBOUNCE  consecutive identical frames needed to change decode (1..15)
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   row[3:0]   row returns, active-low, asynchronous to clk
//   col[3:0]   column drive, active-low, one-hot low
//   decode     debounced key code (k+1), 0 = no key
//   key_press  one-cycle strobe alongside each new nonzero decode value

module keypad_decoder #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] decode,
   output logic       key_press
);

   localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [3:0]       CNT_MAX  = 4'(DEBOUNCE);

   logic [3:0]       row_m;
   logic [3:0]       row_s;
   logic [DIV_W-1:0] div;
   logic [1:0]       ci;
   logic [3:0]       hit;        // best code seen so far this frame, 0 = none
   logic [3:0]       cand;
   logic [3:0]       cnt;

   logic             sample;
   logic             frame_end;
   logic [3:0]       key_idx;
   logic [3:0]       col_code;
   logic [3:0]       merged_code;
   logic [3:0]       cand_n;
   logic [3:0]       cnt_n;
   logic             update;

   assign sample    = (div == DIV_LAST);
   assign frame_end = sample && (ci == 2'd3);
   assign col       = ~(4'b0001 << ci);

   // Lowest pressed row in the driven column. The loop runs from the top row
   // down so the last (lowest-row) hit wins. Key 15 is not a real key.
   always_comb begin
      col_code = 4'd0;
      key_idx  = 4'd0;
      for (int r = 3; r >= 0; r--) begin
         key_idx = {2'(r), ci};
         if (!row_s[r] && (key_idx != 4'hF)) begin
            col_code = key_idx + 4'd1;
         end
      end
   end

   // Keys are not found in index order across columns, so the frame result
   // is a running minimum rather than the first hit.
   always_comb begin
      merged_code = hit;
      if ((col_code != 4'd0) && ((hit == 4'd0) || (col_code < hit))) begin
         merged_code = col_code;
      end
   end

   // At a frame end merged_code is the frame code.
   always_comb begin
      cand_n = cand;
      cnt_n  = cnt;
      if (merged_code == cand) begin
         if (cnt != CNT_MAX) begin
            cnt_n = cnt + 4'd1;
         end
      end else begin
         cand_n = merged_code;
         cnt_n  = 4'd1;
      end
   end

   assign update = frame_end && (cnt_n == CNT_MAX) && (cand_n != decode);

   always_ff @(posedge clk) begin
      if (rst) begin
         row_m     <= 4'd0;
         row_s     <= 4'd0;
         div       <= '0;
         ci        <= 2'd0;
         hit       <= 4'd0;
         cand      <= 4'd0;
         cnt       <= 4'd0;
         decode    <= 4'd0;
         key_press <= 1'b0;
      end else begin
         row_m     <= row;
         row_s     <= row_m;
         key_press <= 1'b0;
         if (sample) begin
            div <= '0;
            ci  <= ci + 2'd1;
            if (ci == 2'd3) begin
               hit  <= 4'd0;
               cand <= cand_n;
               cnt  <= cnt_n;
               if (update) begin
                  decode    <= cand_n;
                  key_press <= (cand_n != 4'd0);
               end
            end else begin
               hit <= merged_code;
            end
         end else begin
            div <= div + DIV_ONE;
         end
      end
   end

endmodule

// File: tb/tb_keypad_decoder.sv
// tb_keypad_decoder
//   Drives keypad_decoder (SCAN_DIV=4, DEBOUNCE=3) from a keypad model that
//   pulls row[r] low while key (r,c) is held and col[c] is low. A frame-level
//   reference model predicts col/decode/key_press every cycle; directed
//   sections pin the model with hand-derived expectations, then random key
//   patterns (with occasional resets) exercise it further.

module tb_keypad_decoder;

   localparam int SD    = 4;
   localparam int DB    = 3;
   localparam int FRAME = 4 * SD;
   localparam int LAT   = (DB + 1) * FRAME + 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  decode;
   logic        key_press;
   logic [15:0] held = 16'h0000;

   int n_checks = 0;
   int n_pass   = 0;
   int kp_count = 0;

   always #5 clk = ~clk;

   keypad_decoder #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .decode    (decode),
      .key_press (key_press)
   );

   for (genvar r = 0; r < 4; r++) begin : g_pad
      assign row[r] = ~|(held[4*r +: 4] & ~col);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Frame schedule follows from cycles since reset; each sample sees the
   // keys held two edges earlier (synchroniser). A frame's code is the lowest
   // valid key index + 1; decode follows once the last DB frame codes agree.
   int          t = 0;
   int          fmin = 16;
   int          fc;
   int          cc;
   int          fhist[$];
   bit          all_eq;
   bit          mvalid = 1'b0;
   logic [15:0] d1 = '0;
   logic [15:0] d2 = '0;
   logic [3:0]  exp_dec = '0;
   logic [3:0]  exp_col = 4'b1110;
   logic        exp_kp = 1'b0;

   always @(posedge clk) begin
      if (rst === 1'b1) begin
         t       = 0;
         d1      = '0;
         d2      = '0;
         fmin    = 16;
         fhist.delete();
         exp_dec = '0;
         exp_kp  = 1'b0;
         mvalid  = 1'b1;
      end else if (mvalid) begin
         exp_kp = 1'b0;
         if (t % SD == SD - 1) begin
            cc = (t / SD) % 4;
            for (int r = 0; r < 4; r++) begin
               if (d2[4*r+cc] && (4*r + cc) != 15 && (4*r + cc) < fmin) fmin = 4*r + cc;
            end
            if (cc == 3) begin
               fc   = (fmin < 15) ? fmin + 1 : 0;
               fmin = 16;
               fhist.push_back(fc);
               if (fhist.size() > DB) void'(fhist.pop_front());
               all_eq = (fhist.size() == DB);
               foreach (fhist[i]) if (fhist[i] != fc) all_eq = 1'b0;
               if (all_eq && fc != int'(exp_dec)) begin
                  exp_dec = 4'(fc);
                  exp_kp  = (fc != 0);
               end
            end
         end
         d2 = d1;
         d1 = held;
         t  = (t + 1) % FRAME;
      end
      exp_col = ~(4'd1 << ((t / SD) % 4));
   end

   always @(negedge clk) begin
      if (mvalid) begin
         check("model_col", 32'(col), 32'(exp_col));
         check("model_decode", 32'(decode), 32'(exp_dec));
         check("model_key_press", 32'(key_press), 32'(exp_kp));
      end
      if (key_press === 1'b1) kp_count++;
   end

   // ---------------- directed helpers ----------------
   task automatic drive(input logic [15:0] m);
      @(posedge clk);
      #1 held = m;
   endtask

   task automatic wait_decode(input string name, input logic [3:0] val, input int limit,
                              output bit saw_zero);
      int n = 0;
      saw_zero = 1'b0;
      while (decode !== val && n < limit) begin
         @(negedge clk);
         if (decode === 4'd0) saw_zero = 1'b1;
         n++;
      end
      check(name, 32'(decode), 32'(val));
   endtask

   logic [3:0] pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   int  kp0;
   int  nz;
   bit  sz;
   logic [15:0] m;
   int  dur;

   initial begin
      // reset while k=6 held
      rst  = 1'b1;
      held = 16'h0040;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_col", 32'(col), 32'(4'b1110));
      check("reset_decode", 32'(decode), 32'd0);
      check("reset_key_press", 32'(key_press), 32'd0);
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         check("col_sequence", 32'(col), 32'(pat[i/4]));
      end
      wait_decode("initial_hold_k6", 4'd7, LAT, sz);
      drive(16'h0000);
      wait_decode("initial_release", 4'd0, LAT, sz);
      repeat (FRAME) @(negedge clk);

      // single press / release
      kp0 = kp_count;
      drive(16'h0040);
      wait_decode("press_k6", 4'd7, LAT, sz);
      repeat (2 * FRAME) @(negedge clk);
      check("press_k6_pulses", 32'(kp_count - kp0), 32'd1);
      kp0 = kp_count;
      drive(16'h0000);
      wait_decode("release_k6", 4'd0, LAT, sz);
      repeat (2 * FRAME) @(negedge clk);
      check("release_k6_pulses", 32'(kp_count - kp0), 32'd0);

      // bounce on k=11, phase-aligned to the frame so no 3-frame run forms
      do begin
         @(posedge clk);
         #1;
      end while (t % FRAME != 2);
      kp0  = kp_count;
      nz   = 0;
      held = 16'h0800;
      for (int i = 1; i <= 120; i++) begin
         @(posedge clk);
         #1;
         if (decode !== 4'd0) nz++;
         if (i % 10 == 0) held = held ^ 16'h0800;
      end
      check("bounce_quiet", 32'(nz), 32'd0);
      wait_decode("bounce_settle_k11", 4'd12, LAT, sz);
      repeat (2 * FRAME) @(negedge clk);
      check("bounce_pulses", 32'(kp_count - kp0), 32'd1);
      drive(16'h0000);
      wait_decode("bounce_release", 4'd0, LAT, sz);

      // priority: k=2 (col 2) beats k=9 (col 1) though k=9 is scanned first
      drive(16'h0204);
      wait_decode("priority_k2", 4'd3, LAT, sz);
      repeat (2 * FRAME) @(negedge clk);
      kp0 = kp_count;
      drive(16'h0200);
      wait_decode("priority_k9", 4'd10, LAT, sz);
      check("priority_no_zero", 32'(sz), 32'd0);
      repeat (2 * FRAME) @(negedge clk);
      check("priority_pulses", 32'(kp_count - kp0), 32'd1);
      drive(16'h0000);
      wait_decode("priority_release", 4'd0, LAT, sz);
      repeat (FRAME) @(negedge clk);

      // unused key 15
      kp0 = kp_count;
      nz  = 0;
      drive(16'h8000);
      repeat (10 * FRAME) begin
         @(negedge clk);
         if (decode !== 4'd0) nz++;
      end
      check("unused_k15_decode", 32'(nz), 32'd0);
      check("unused_k15_pulses", 32'(kp_count - kp0), 32'd0);
      drive(16'h0000);

      // reset mid-press
      drive(16'h0040);
      wait_decode("midreset_hold", 4'd7, LAT, sz);
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      kp0 = kp_count;
      @(negedge clk);
      check("midreset_decode", 32'(decode), 32'd0);
      check("midreset_key_press", 32'(key_press), 32'd0);
      wait_decode("midreset_return", 4'd7, LAT, sz);
      repeat (2 * FRAME) @(negedge clk);
      check("midreset_pulses", 32'(kp_count - kp0), 32'd1);

      // random key patterns
      for (int it = 0; it < 120; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2:    m = 16'h0000;
            3, 4, 5, 6: m = 16'h0001 << $urandom_range(0, 15);
            7, 8:       m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            default:    m = 16'($urandom);
         endcase
         dur = $urandom_range(1, 160);
         drive(m);
         repeat (dur) @(posedge clk);
         if (it % 29 == 28) begin
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
         end
      end
      drive(16'h0000);
      repeat (6 * FRAME) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule
